// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//
// Purpose: accepts one operation at a time from requester 0 or 1 (valid/ready),
// holds the latched operands on the ALU for ALU_LAT cycles, captures the ALU
// result and zero flag, then pulses the matching rspN_valid for one cycle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   reqN_valid/ready              request handshake, N = 0/1
//   reqN_src1/src2/ctr            request operands and ALU control
//   rsp0_valid, rsp1_valid        one-cycle response pulses
//   rsp_result, rsp_zero          captured ALU result / zero flag
//   busy                          high whenever an operation is in flight
//   alu_src1/src2/ctr             operands driven to the ALU
//   alu_result, zero_bit          ALU outputs

module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int CTR_W   = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_src1,
    input  logic [WIDTH-1:0] req0_src2,
    input  logic [CTR_W-1:0] req0_ctr,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_src1,
    input  logic [WIDTH-1:0] req1_src2,
    input  logic [CTR_W-1:0] req1_ctr,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [CTR_W-1:0] alu_ctr,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             zero_bit
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             grant;
    logic             grant_id;
    logic             any_valid;
    logic             accept;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;
    logic [CTR_W-1:0] ctr_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    // Winner selection: a lone valid wins outright; on a tie the requester
    // that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign any_valid = req0_valid | req1_valid;
    assign accept    = (state == IDLE) && any_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req0_ready = any_valid && !grant;
                req1_ready = any_valid && grant;
                if (any_valid) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are sampled only on the accept edge; they then stay on the ALU
    // until the next accept, so the ALU inputs never glitch between ops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            cnt        <= 4'd0;
            src1_q     <= '0;
            src2_q     <= '0;
            ctr_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_id <= grant;
                        cnt      <= LAT_M1;
                        src1_q   <= grant ? req1_src1 : req0_src1;
                        src2_q   <= grant ? req1_src2 : req0_src2;
                        ctr_q    <= grant ? req1_ctr  : req0_ctr;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        result_q <= alu_result;
                        zero_q   <= zero_bit;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    last_grant <= grant_id;
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign alu_ctr    = ctr_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (ALU_LAT=1 and ALU_LAT=4)

module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_src1 = '0, req0_src2 = '0, req1_src1 = '0, req1_src2 = '0;
    logic [2:0]  req0_ctr = '0, req1_ctr = '0;
    logic        rsp0_valid, rsp1_valid, rsp_zero, busy, zero_bit;
    logic [31:0] rsp_result, alu_src1, alu_src2, alu_result;
    logic [2:0]  alu_ctr;

    logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0;
    logic        b_req0_ready, b_req1_ready;
    logic [31:0] b_req0_src1 = '0, b_req0_src2 = '0, b_req1_src1 = '0, b_req1_src2 = '0;
    logic [2:0]  b_req0_ctr = '0, b_req1_ctr = '0;
    logic        b_rsp0_valid, b_rsp1_valid, b_rsp_zero, b_busy, b_zero_bit;
    logic [31:0] b_rsp_result, b_alu_src1, b_alu_src2, b_alu_result;
    logic [2:0]  b_alu_ctr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] c);
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result   = alu_f(alu_src1, alu_src2, alu_ctr);
    assign zero_bit     = (alu_result == 32'd0);
    assign b_alu_result = alu_f(b_alu_src1, b_alu_src2, b_alu_ctr);
    assign b_zero_bit   = (b_alu_result == 32'd0);

    alu_arbiter #(.WIDTH(32), .CTR_W(3), .ALU_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_ctr(req0_ctr),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_ctr(req1_ctr),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctr(alu_ctr),
        .alu_result(alu_result), .zero_bit(zero_bit)
    );

    alu_arbiter #(.WIDTH(32), .CTR_W(3), .ALU_LAT(4)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
        .req0_src1(b_req0_src1), .req0_src2(b_req0_src2), .req0_ctr(b_req0_ctr),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
        .req1_src1(b_req1_src1), .req1_src2(b_req1_src2), .req1_ctr(b_req1_ctr),
        .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid),
        .rsp_result(b_rsp_result), .rsp_zero(b_rsp_zero), .busy(b_busy),
        .alu_src1(b_alu_src1), .alu_src2(b_alu_src2), .alu_ctr(b_alu_ctr),
        .alu_result(b_alu_result), .zero_bit(b_zero_bit)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g;

        // Reset state
        tick();
        tick();
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_rsp0",   32'(rsp0_valid), 32'd0);
        chk("rst_rsp1",   32'(rsp1_valid), 32'd0);
        chk("rst_src1",   alu_src1, 32'd0);
        chk("rst_ctr",    32'(alu_ctr), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero",   32'(rsp_zero), 32'd0);
        rst = 1'b1;

        // req0 only: 2 - 2 = 0
        tick();
        req0_valid = 1'b1; req0_src1 = 32'd2; req0_src2 = 32'd2; req0_ctr = 3'b110;
        #1;
        chk("t2_ready0", 32'(req0_ready), 32'd1);
        chk("t2_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t2_busy",     32'(busy), 32'd1);
        chk("t2_ready0_x", 32'(req0_ready), 32'd0);
        chk("t2_alu_src1", alu_src1, 32'd2);
        chk("t2_rsp0_early", 32'(rsp0_valid), 32'd0);
        tick();
        chk("t2_rsp0",   32'(rsp0_valid), 32'd1);
        chk("t2_rsp1",   32'(rsp1_valid), 32'd0);
        chk("t2_result", rsp_result, 32'd0);
        chk("t2_zero",   32'(rsp_zero), 32'd1);
        tick();
        chk("t2_rsp0_end", 32'(rsp0_valid), 32'd0);
        chk("t2_idle",     32'(busy), 32'd0);

        // Reset mid-EXEC drops the op; pending valid is accepted afterwards
        req0_valid = 1'b1; req0_src1 = 32'd4; req0_src2 = 32'd1; req0_ctr = 3'b110;
        tick();
        chk("t1_exec_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("t1_busy_rst", 32'(busy), 32'd0);
        chk("t1_src1_rst", alu_src1, 32'd0);
        tick();
        chk("t1_rsp0_rst", 32'(rsp0_valid), 32'd0);
        chk("t1_busy_hold", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("t1_rsp0_none", 32'(rsp0_valid), 32'd0);
        chk("t1_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("t1_src1", alu_src1, 32'd4);
        tick();
        chk("t1_rsp0",   32'(rsp0_valid), 32'd1);
        chk("t1_result", rsp_result, 32'd3);

        // Fresh reset, then both valid: req0 first; req1 operands change while waiting
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_src1 = 32'd1; req0_src2 = 32'd0; req0_ctr = 3'b010;
        req1_valid = 1'b1; req1_src1 = 32'd7; req1_src2 = 32'd7; req1_ctr = 3'b010;
        #1;
        chk("t3_ready0", 32'(req0_ready), 32'd1);
        chk("t3_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t3_ready1_exec", 32'(req1_ready), 32'd0);
        tick();
        chk("t3_rsp0",   32'(rsp0_valid), 32'd1);
        chk("t3_rsp1_a", 32'(rsp1_valid), 32'd0);
        chk("t3_res0",   rsp_result, 32'd1);
        chk("t3_zero0",  32'(rsp_zero), 32'd0);
        chk("t3_ready1_done", 32'(req1_ready), 32'd0);
        req1_src1 = 32'd5; req1_src2 = 32'd3; req1_ctr = 3'b110;
        tick();
        chk("t3_ready1_idle", 32'(req1_ready), 32'd1);
        chk("t3_ready0_idle", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        chk("t6_alu_src1", alu_src1, 32'd5);
        chk("t6_alu_src2", alu_src2, 32'd3);
        chk("t6_alu_ctr",  32'(alu_ctr), 32'd6);
        tick();
        chk("t3_rsp1",   32'(rsp1_valid), 32'd1);
        chk("t3_rsp0_b", 32'(rsp0_valid), 32'd0);
        chk("t3_res1",   rsp_result, 32'd2);
        chk("t3_zero1",  32'(rsp_zero), 32'd0);
        tick();

        // Both held valid for 8 ops: grants alternate 0,1,0,1...
        req0_valid = 1'b1; req0_src1 = 32'd10; req0_src2 = 32'd3; req0_ctr = 3'b010;
        req1_valid = 1'b1; req1_src1 = 32'd10; req1_src2 = 32'd3; req1_ctr = 3'b110;
        #1;
        g = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t4_ready0", 32'(req0_ready), 32'(!g));
            chk("t4_ready1", 32'(req1_ready), 32'(g));
            tick();
            tick();
            chk("t4_rsp0",   32'(rsp0_valid), 32'(!g));
            chk("t4_rsp1",   32'(rsp1_valid), 32'(g));
            chk("t4_result", rsp_result, g ? 32'd7 : 32'd13);
            tick();
            g = ~g;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // ALU_LAT=4 instance: operands held 4 cycles, response 5 cycles after accept
        b_req1_valid = 1'b1; b_req1_src1 = 32'd6; b_req1_src2 = 32'd6; b_req1_ctr = 3'b110;
        #1;
        chk("t5_ready1", 32'(b_req1_ready), 32'd1);
        chk("t5_ready0", 32'(b_req0_ready), 32'd0);
        tick();
        b_req1_valid = 1'b0; b_req1_src1 = 32'hdead_beef; b_req1_src2 = 32'h1234; b_req1_ctr = 3'b001;
        for (int k = 0; k < 4; k++) begin
            chk("t5_busy", 32'(b_busy), 32'd1);
            chk("t5_src1", b_alu_src1, 32'd6);
            chk("t5_src2", b_alu_src2, 32'd6);
            chk("t5_ctr",  32'(b_alu_ctr), 32'd6);
            chk("t5_rsp1_early", 32'(b_rsp1_valid), 32'd0);
            tick();
        end
        chk("t5_rsp1",   32'(b_rsp1_valid), 32'd1);
        chk("t5_rsp0",   32'(b_rsp0_valid), 32'd0);
        chk("t5_result", b_rsp_result, 32'd0);
        chk("t5_zero",   32'(b_rsp_zero), 32'd1);
        tick();
        chk("t5_rsp1_end", 32'(b_rsp1_valid), 32'd0);
        chk("t5_idle",     32'(b_busy), 32'd0);
        chk("t5_src_hold", b_alu_src1, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
